// File: rtl/rca_pipe_pkg.sv
// Shared constants, sizing helper and stage record for the pipelined
// ripple-carry adder/subtractor (rca_pipe).
package rca_pipe_pkg;

    localparam int unsigned RCA_WIDTH_DEFAULT  = 16;
    localparam int unsigned RCA_STAGES_DEFAULT = 4;

    // Bits added by each pipeline stage.
    function automatic int unsigned rca_chunk_width(input int unsigned width,
                                                    input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    // Per-stage record at the default size. rca_pipe declares the same layout
    // sized by its own WIDTH parameter.
    typedef struct packed {
        logic                         valid;
        logic                         carry;
        logic [RCA_WIDTH_DEFAULT-1:0] sum;
        logic [RCA_WIDTH_DEFAULT-1:0] a;
        logic [RCA_WIDTH_DEFAULT-1:0] b;
    } rca_stage_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple of full_adder cells; one instance per pipeline stage.
module rca_chunk
    import rca_pipe_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out
);

    // Each bit keeps its own carry nets so the chain is not one self-referencing vector.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = c_in;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (ci),
            .s     (s[i]),
            .c_out (co)
        );
    end

    assign c_out = g_bit[W-1].co;

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshakes.
// Stage k adds operand bits [k*CHUNK +: CHUNK] using the carry registered by
// stage k-1; the last stage register is the output register.
// Optional build macro RCA_PIPE_OVF_EN adds a registered signed-overflow output 'ovf'.
module rca_pipe
    import rca_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = RCA_WIDTH_DEFAULT,
    parameter int unsigned STAGES = RCA_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CHUNK = rca_chunk_width(WIDTH, STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("rca_pipe: WIDTH must be >= 1 and an exact multiple of STAGES");
    end

    // Upper operand bits ride along unmodified (skew); finished low sum chunks
    // ride along in 'sum' (deskew). Synthesis trims the bits a stage never uses.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t           st_q [STAGES];
    stage_t           st_d [STAGES];
    stage_t           src  [STAGES];
    logic [CHUNK-1:0] ch_s [STAGES];
    logic             ch_c [STAGES];
    logic             advance;

    // Whole pipeline moves together; it only stalls when a held result is unclaimed.
    assign advance   = !st_q[LAST].valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = st_q[LAST].valid;
    assign s         = st_q[LAST].sum;
    assign c_out     = st_q[LAST].carry;

    // Stage sources: the input beat (B inverted, carry forced for subtract) or the previous register.
    always_comb begin
        src[0].valid = in_valid;
        src[0].carry = sub ? 1'b1 : c_in;
        src[0].sum   = '0;
        src[0].a     = a;
        src[0].b     = sub ? ~b : b;
        for (int k = 1; k < int'(STAGES); k++) begin
            src[k] = st_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(.W(CHUNK)) u_chunk (
            .a     (src[k].a[k*CHUNK +: CHUNK]),
            .b     (src[k].b[k*CHUNK +: CHUNK]),
            .c_in  (src[k].carry),
            .s     (ch_s[k]),
            .c_out (ch_c[k])
        );
    end

    // Next stage contents; the output stage keeps its last data when a bubble arrives.
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            st_d[k]                       = src[k];
            st_d[k].sum[k*CHUNK +: CHUNK] = ch_s[k];
            st_d[k].carry                 = ch_c[k];
        end
        if (!src[LAST].valid) begin
            st_d[LAST]       = st_q[LAST];
            st_d[LAST].valid = 1'b0;
        end
    end

    // Stage registers: cleared by reset (drops in-flight beats), shift only on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                st_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

`ifdef RCA_PIPE_OVF_EN
    logic msb_cin;
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        msb_cin = ch_s[LAST][CHUNK-1] ^ src[LAST].a[WIDTH-1] ^ src[LAST].b[WIDTH-1];
        ovf_d   = src[LAST].valid ? (msb_cin ^ ch_c[LAST]) : ovf_q;
    end

    // Overflow flag registered alongside s with the same hold behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: directed vectors, backpressure and reset sequences on a
// 16/4 instance, plus random sweeps on 16/4, 8/1 and 32/8 instances.
module tb_rca_pipe;

    localparam int W0 = 16, S0 = 4;
    localparam int W1 = 8,  S1 = 1;
    localparam int W2 = 32, S2 = 8;
    localparam int N_RAND = 10000;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          acc;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_in_valid  [3];
    logic        i_out_ready [3];
    logic [63:0] i_a         [3];
    logic [63:0] i_b         [3];
    logic        i_cin       [3];
    logic        i_sub       [3];
    logic        o_in_ready  [3];
    logic        o_out_valid [3];
    logic        o_c_out     [3];
    logic        o_ovf       [3];
    logic [W0-1:0] s0;
    logic [W1-1:0] s1;
    logic [W2-1:0] s2;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   stall_cnt [3] = '{0, 0, 0};
    exp_t exp_q [3][$];

    rca_pipe #(.WIDTH(W0), .STAGES(S0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(i_in_valid[0]), .in_ready(o_in_ready[0]),
        .a(i_a[0][W0-1:0]), .b(i_b[0][W0-1:0]), .c_in(i_cin[0]), .sub(i_sub[0]),
        .out_valid(o_out_valid[0]), .out_ready(i_out_ready[0]), .s(s0), .c_out(o_c_out[0])
`ifdef RCA_PIPE_OVF_EN
        , .ovf(o_ovf[0])
`endif
    );

    rca_pipe #(.WIDTH(W1), .STAGES(S1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(i_in_valid[1]), .in_ready(o_in_ready[1]),
        .a(i_a[1][W1-1:0]), .b(i_b[1][W1-1:0]), .c_in(i_cin[1]), .sub(i_sub[1]),
        .out_valid(o_out_valid[1]), .out_ready(i_out_ready[1]), .s(s1), .c_out(o_c_out[1])
`ifdef RCA_PIPE_OVF_EN
        , .ovf(o_ovf[1])
`endif
    );

    rca_pipe #(.WIDTH(W2), .STAGES(S2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(i_in_valid[2]), .in_ready(o_in_ready[2]),
        .a(i_a[2][W2-1:0]), .b(i_b[2][W2-1:0]), .c_in(i_cin[2]), .sub(i_sub[2]),
        .out_valid(o_out_valid[2]), .out_ready(i_out_ready[2]), .s(s2), .c_out(o_c_out[2])
`ifdef RCA_PIPE_OVF_EN
        , .ovf(o_ovf[2])
`endif
    );

`ifndef RCA_PIPE_OVF_EN
    assign o_ovf[0] = 1'b0;
    assign o_ovf[1] = 1'b0;
    assign o_ovf[2] = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
    endfunction

    // Reference: plain modular arithmetic and signed range test.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int w);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] full;
        longint      r;
        longint      lim;
        m = (64'(1) << w) - 64'(1);
        a = a & m;
        b = b & m;
        if (sub) full = a + ((64'(1) << w) - b);
        else     full = a + b + 64'(cin);
        e.s = full & m;
        e.c = full[w];
        r   = sub ? sx(a, w) - sx(b, w) : sx(a, w) + sx(b, w) + longint'(cin);
        lim = longint'(1) << (w - 1);
        e.o = (r >= lim) || (r < -lim);
        e.acc = 0;
        e.stalls = 0;
        return e;
    endfunction

    // Scoreboard for one instance, sampled mid-cycle.
    task automatic mon(input int id, input int w, input int stg,
                       input logic [63:0] s_act, input logic c_act, input logic ovf_act);
        exp_t e;
        if (rst) begin
            exp_q[id].delete();
            return;
        end
        chk($sformatf("in_ready%0d", id), 64'(o_in_ready[id]),
            64'(!o_out_valid[id] || i_out_ready[id]));
        if (o_out_valid[id]) begin
            chk($sformatf("pending%0d", id), 64'(exp_q[id].size() != 0), 64'(1));
            if (exp_q[id].size() != 0) begin
                e = exp_q[id][0];
                chk($sformatf("s%0d", id), s_act, e.s);
                chk($sformatf("c_out%0d", id), 64'(c_act), 64'(e.c));
`ifdef RCA_PIPE_OVF_EN
                chk($sformatf("ovf%0d", id), 64'(ovf_act), 64'(e.o));
`else
                if (ovf_act !== 1'b0) chk($sformatf("ovf_tie%0d", id), 64'(ovf_act), 64'(0));
`endif
                if (i_out_ready[id]) begin
                    void'(exp_q[id].pop_front());
                    if (e.stalls == stall_cnt[id])
                        chk($sformatf("latency%0d", id), 64'(cyc - e.acc), 64'(stg));
                end
            end
        end
        if (i_in_valid[id] && o_in_ready[id]) begin
            e = model(i_a[id], i_b[id], i_cin[id], i_sub[id], w);
            e.acc = cyc;
            e.stalls = stall_cnt[id];
            exp_q[id].push_back(e);
        end
        if (o_out_valid[id] && !i_out_ready[id]) stall_cnt[id]++;
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, W0, S0, 64'(s0), o_c_out[0], o_ovf[0]);
        mon(1, W1, S1, 64'(s1), o_c_out[1], o_ovf[1]);
        mon(2, W2, S2, 64'(s2), o_c_out[2], o_ovf[2]);
    end

    // One beat through the 16/4 instance with no backpressure.
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        @(posedge clk); #1;
        i_a[0] = 64'(v.a); i_b[0] = 64'(v.b); i_cin[0] = v.cin; i_sub[0] = v.sub;
        i_out_ready[0] = 1'b1;
        i_in_valid[0] = 1'b1;
        @(posedge clk); #1;
        i_in_valid[0] = 1'b0;
        n = 1;
        while (!o_out_valid[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(n), 64'(S0));
        chk($sformatf("vec%0d_s", idx), 64'(s0), 64'(v.s));
        chk($sformatf("vec%0d_c_out", idx), 64'(o_c_out[0]), 64'(v.c));
`ifdef RCA_PIPE_OVF_EN
        chk($sformatf("vec%0d_ovf", idx), 64'(o_ovf[0]), 64'(v.o));
`endif
    endtask

    task automatic rand_drive(input int id, input int w, input int nbeats);
        int acc = 0;
        int guard = 0;
        logic [63:0] mask;
        mask = (64'(1) << w) - 64'(1);
        while (acc < nbeats && guard < 40000) begin
            @(posedge clk); #1;
            i_in_valid[id]  = ($urandom_range(3) != 0);
            i_a[id]         = {$urandom, $urandom} & mask;
            i_b[id]         = {$urandom, $urandom} & mask;
            if ($urandom_range(7) == 0) i_a[id] = mask;
            if ($urandom_range(7) == 0) i_b[id] = ($urandom_range(1) == 0) ? mask : 64'(0);
            i_cin[id]       = 1'($urandom_range(1));
            i_sub[id]       = 1'($urandom_range(1));
            i_out_ready[id] = ($urandom_range(4) != 0);
            @(negedge clk);
            if (i_in_valid[id] && o_in_ready[id]) acc++;
            guard++;
        end
        chk($sformatf("rand_beats%0d", id), 64'(acc), 64'(nbeats));
        @(posedge clk); #1;
        i_in_valid[id]  = 1'b0;
        i_out_ready[id] = 1'b1;
        guard = 0;
        while (exp_q[id].size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk($sformatf("rand_drain%0d", id), 64'(exp_q[id].size()), 64'(0));
    endtask

    vec_t vecs [11];

    initial begin
        int idx;
        int r;
        bit acc;
        bit em;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2]  = '{16'h1234, 16'h0034, 1'b0, 1'b1, 16'h1200, 1'b1, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[10] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_in_valid[i] = 1'b0; i_out_ready[i] = 1'b1;
            i_a[i] = '0; i_b[i] = '0; i_cin[i] = 1'b0; i_sub[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 64'(o_out_valid[0]), 64'(0));
        chk("rst_in_ready", 64'(o_in_ready[0]), 64'(1));
        chk("rst_s", 64'(s0), 64'(0));
        chk("rst_c_out", 64'(o_c_out[0]), 64'(0));
`ifdef RCA_PIPE_OVF_EN
        chk("rst_ovf", 64'(o_ovf[0]), 64'(0));
`endif

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Backpressure: 8 beats, downstream not ready for cycles 5..9.
        idx = 0;
        r = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 60 && r < 8; c++) begin
            i_out_ready[0] = !(c >= 5 && c <= 9);
            i_in_valid[0]  = (idx < 8);
            i_a[0] = 64'(idx); i_b[0] = 64'h0100; i_cin[0] = 1'b1; i_sub[0] = 1'b0;
            @(negedge clk);
            if (c == 5) chk("bp_in_ready_low", 64'(o_in_ready[0]), 64'(0));
            if (o_out_valid[0]) chk($sformatf("bp_s%0d", r), 64'(s0), 64'(r + 16'h0101));
            acc = i_in_valid[0] && o_in_ready[0];
            em  = o_out_valid[0] && i_out_ready[0];
            @(posedge clk); #1;
            if (acc) idx++;
            if (em) r++;
        end
        i_in_valid[0]  = 1'b0;
        i_out_ready[0] = 1'b1;
        chk("bp_accepted", 64'(idx), 64'(8));
        chk("bp_received", 64'(r), 64'(8));

        // Reset with three beats in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            i_in_valid[0] = 1'b1;
            i_a[0] = 64'(i + 1); i_b[0] = 64'h1; i_cin[0] = 1'b0; i_sub[0] = 1'b0;
            @(posedge clk); #1;
        end
        i_in_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_out_valid", 64'(o_out_valid[0]), 64'(0));
        chk("mrst_in_ready", 64'(o_in_ready[0]), 64'(1));
        chk("mrst_s", 64'(s0), 64'(0));
        chk("mrst_c_out", 64'(o_c_out[0]), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mrst_quiet%0d", i), 64'(o_out_valid[0]), 64'(0));
        end
        run_vec(99, vecs[5]);

        fork
            rand_drive(0, W0, N_RAND);
            rand_drive(1, W1, N_RAND);
            rand_drive(2, W2, N_RAND);
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
